// File: rtl/fpu_issue_seq.sv
// Issue sequencer between the core and the FPU arithmetic unit: registers one operation,
// holds start until done, returns the result and accrues fflags. Optional watchdog: FPU_ISSUE_WDOG_EN.
module fpu_issue_seq #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_rm,
  input  logic        req_rs2_lsb,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic        fpu_rs2_lsb,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic        fpu_done,
  input  logic [4:0]  fpu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic [4:0]  rsp_flags,
  output logic [4:0]  fflags,
  input  logic        csr_fflags_we,
  input  logic [4:0]  csr_fflags_wdata,
  output logic        busy,
  output logic        wdog_trip
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [2:0]  rm_q, rm_d;
  logic        lsb_q, lsb_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_flags_q, rsp_flags_d;
  logic [4:0]  fflags_q, fflags_d;
  logic        wdog_trip_q, wdog_trip_d;
  logic        accept, capture, trip;
  logic [31:0] cap_data;
  logic [4:0]  cap_flags;

`ifdef FPU_ISSUE_WDOG_EN
  localparam logic [7:0] WdogLimit = 8'(WDOG_CYCLES - 1);
  logic [7:0] wdog_cnt_q, wdog_cnt_d;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (accept) begin
      wdog_cnt_d = '0;
    end else if (state_q == StExec && !fpu_done) begin
      wdog_cnt_d = wdog_cnt_q + 8'd1;
    end
  end

  // A done arriving on the limit cycle wins over the abort.
  assign trip = (state_q == StExec) && !fpu_done && (wdog_cnt_q == WdogLimit);

  always_ff @(posedge clk) begin
    if (reset) wdog_cnt_q <= '0;
    else       wdog_cnt_q <= wdog_cnt_d;
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign trip        = 1'b0;
`endif

  assign req_ready = !reset && (state_q == StIdle || (state_q == StResp && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign capture   = (state_q == StExec) && (fpu_done || trip);
  assign cap_data  = fpu_done ? fpu_result : 32'h7FC0_0000;
  assign cap_flags = fpu_done ? fpu_flags : 5'b10000;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rm_d        = rm_q;
    lsb_d       = lsb_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    wdog_trip_d = trip;

    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  if (capture) state_d = StResp;
      StResp:  if (rsp_ready) state_d = accept ? StExec : StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d  = req_op;
      rm_d  = req_rm;
      lsb_d = req_rs2_lsb;
      a_d   = req_a;
      b_d   = req_b;
      rd_d  = req_rd;
    end

    if (capture) begin
      rsp_data_d  = cap_data;
      rsp_flags_d = cap_flags;
    end

    // CSR write lands first, then the captured flags accrue on top.
    fflags_d = (csr_fflags_we ? csr_fflags_wdata : fflags_q) | (capture ? cap_flags : 5'b0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      rm_q        <= '0;
      lsb_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      fflags_q    <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rm_q        <= rm_d;
      lsb_q       <= lsb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      fflags_q    <= fflags_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign fpu_start   = (state_q == StExec);
  assign fpu_op      = op_q;
  assign fpu_rm      = rm_q;
  assign fpu_rs2_lsb = lsb_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign rsp_rd      = rd_q;
  assign rsp_flags   = rsp_flags_q;
  assign fflags      = fflags_q;
  assign busy        = (state_q != StIdle);
  assign wdog_trip   = wdog_trip_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Self-checking bench for fpu_issue_seq: directed plus randomized transactions checked against a
// transaction-level model of latency, payload and fflags accrual.
module tb_fpu_issue_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [4:0]  req_op = '0;
  logic [2:0]  req_rm = '0;
  logic        req_rs2_lsb = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        fpu_start, fpu_rs2_lsb;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a, fpu_b;
  logic [31:0] fpu_result = '0;
  logic        fpu_done = 1'b0;
  logic [4:0]  fpu_flags = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd, rsp_flags, fflags;
  logic        csr_fflags_we = 1'b0;
  logic [4:0]  csr_fflags_wdata = '0;
  logic        busy, wdog_trip;

  always #5 clk = ~clk;

  fpu_issue_seq #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_rs2_lsb(req_rs2_lsb), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_rs2_lsb(fpu_rs2_lsb),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result), .fpu_done(fpu_done),
    .fpu_flags(fpu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_flags(rsp_flags), .fflags(fflags),
    .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
    .busy(busy), .wdog_trip(wdog_trip)
  );

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rm;
    logic        lsb;
    logic [31:0] a, b, res;
    logic [4:0]  rd, flg, cd;
    int          n, stall;
    bit          b2b, cw;
  } txn_t;

  localparam int NT = 24;
  txn_t       t[NT];
  int         tests = 0, fails = 0;
  logic [4:0] exp_ff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic present(input int i);
    req_valid   = 1'b1;
    req_op      = t[i].op;
    req_rm      = t[i].rm;
    req_rs2_lsb = t[i].lsb;
    req_a       = t[i].a;
    req_b       = t[i].b;
    req_rd      = t[i].rd;
  endtask

  task automatic idle_req();
    req_valid   = 1'b0;
    req_op      = 5'($urandom);
    req_rm      = 3'($urandom);
    req_rs2_lsb = 1'($urandom);
    req_a       = $urandom;
    req_b       = $urandom;
    req_rd      = 5'($urandom);
  endtask

  task automatic noise_fpu();
    fpu_done   = 1'($urandom);
    fpu_result = $urandom;
    fpu_flags  = 5'($urandom);
  endtask

  task automatic chk_rsp(input string tag, input int i);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, rsp_data, t[i].res);
    chk({tag, "_flags"}, 32'(rsp_flags), 32'(t[i].flg));
    chk({tag, "_rd"}, 32'(rsp_rd), 32'(t[i].rd));
    chk({tag, "_fflags"}, 32'(fflags), 32'(exp_ff));
    chk({tag, "_start"}, 32'(fpu_start), 32'd0);
    chk({tag, "_hold_a"}, fpu_a, t[i].a);
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      t[i].op = 5'($urandom);   t[i].rm = 3'($urandom); t[i].lsb = 1'($urandom);
      t[i].a = $urandom;        t[i].b = $urandom;      t[i].res = $urandom;
      t[i].rd = 5'($urandom);   t[i].flg = 5'($urandom); t[i].cd = 5'($urandom);
      t[i].n = int'($urandom_range(1, 12));
      t[i].stall = int'($urandom_range(0, 3));
      t[i].b2b = 1'($urandom);
      t[i].cw = ($urandom_range(0, 3) == 0);
    end
    // Directed head of the sequence.
    t[0].op = 5'b00000; t[0].a = 32'h3F80_0000; t[0].b = 32'h4000_0000;
    t[0].res = 32'h4040_0000; t[0].n = 1; t[0].flg = 5'b0; t[0].stall = 0;
    t[0].b2b = 0; t[0].cw = 0;
    t[1].op = 5'b00011; t[1].n = 10; t[1].flg = 5'b01000; t[1].cw = 0; t[1].b2b = 0;
    t[2].n = 1; t[2].flg = 5'b00001; t[2].cw = 0; t[2].b2b = 0; t[2].stall = 0;
    t[3].n = 3; t[3].stall = 5; t[3].b2b = 1; t[3].cw = 0;
    t[4].n = 1; t[4].flg = 5'b00001; t[4].cw = 1; t[4].cd = 5'b00000; t[4].b2b = 0;
    t[NT-1].b2b = 0;

    // Reset
    idle_req();
    step(); step();
    sample();
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    present(0);
    sample();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_start", 32'(fpu_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdog", 32'(wdog_trip), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rdflags", {22'd0, rsp_rd, rsp_flags}, 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_fpu_ab", fpu_a | fpu_b, 32'd0);
    chk("rst_fpu_fields", {23'd0, fpu_op, fpu_rm, fpu_rs2_lsb}, 32'd0);
    exp_ff = '0;

    for (int i = 0; i < NT; i++) begin
      bit nxt;
      nxt = t[i].b2b && (i + 1 < NT);
      for (int k = 1; k <= t[i].n; k++) begin
        step();
        idle_req();
        rsp_ready        = 1'($urandom);
        fpu_done         = (k == t[i].n);
        fpu_result       = (k == t[i].n) ? t[i].res : $urandom;
        fpu_flags        = (k == t[i].n) ? t[i].flg : 5'($urandom);
        csr_fflags_we    = (k == t[i].n) && t[i].cw;
        csr_fflags_wdata = t[i].cd;
        sample();
        chk("exec_start", 32'(fpu_start), 32'd1);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_wdog", 32'(wdog_trip), 32'd0);
        chk("exec_fflags", 32'(fflags), 32'(exp_ff));
        chk("exec_a", fpu_a, t[i].a);
        chk("exec_b", fpu_b, t[i].b);
        chk("exec_fields", {23'd0, fpu_op, fpu_rm, fpu_rs2_lsb},
            {23'd0, t[i].op, t[i].rm, t[i].lsb});
      end
      exp_ff = (t[i].cw ? t[i].cd : exp_ff) | t[i].flg;

      for (int s = 0; s < t[i].stall; s++) begin
        step();
        noise_fpu();
        csr_fflags_we = 1'b0;
        rsp_ready     = 1'b0;
        if (nxt) present(i + 1);
        else     idle_req();
        sample();
        chk("stall_ready", 32'(req_ready), 32'd0);
        chk_rsp("stall", i);
      end

      step();
      noise_fpu();
      csr_fflags_we = 1'b0;
      rsp_ready     = 1'b1;
      if (nxt) present(i + 1);
      else     idle_req();
      sample();
      chk("hs_ready", 32'(req_ready), 32'd1);
      chk_rsp("hs", i);

      if (!nxt) begin
        step();
        idle_req();
        noise_fpu();
        rsp_ready        = 1'($urandom);
        csr_fflags_we    = (i >= 4) && ($urandom_range(0, 2) == 0);
        csr_fflags_wdata = 5'($urandom);
        sample();
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_start", 32'(fpu_start), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_hold_a", fpu_a, t[i].a);
        chk("idle_fflags", 32'(fflags), 32'(exp_ff));
        if (csr_fflags_we) exp_ff = csr_fflags_wdata;
        if (i + 1 < NT) present(i + 1);
        else            present(0);
      end
    end

    // FSQRT aborted by reset in its 3rd EXEC cycle (request from the last idle cycle).
    req_op = 5'b01011;
    step();
    idle_req();
    fpu_done = 1'b0;
    csr_fflags_we = 1'b1;
    csr_fflags_wdata = 5'b10101;
    sample();
    chk("pre_rst_start", 32'(fpu_start), 32'd1);
    step();
    csr_fflags_we = 1'b0;
    sample();
    chk("pre_rst_fflags", 32'(fflags), 32'h15);
    step();
    reset = 1'b1;
    sample();
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    sample();
    chk("post_rst_start", 32'(fpu_start), 32'd0);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_fflags", 32'(fflags), 32'd0);
    chk("post_rst_rsp", rsp_data | {22'd0, rsp_rd, rsp_flags}, 32'd0);
    chk("post_rst_fpu_a", fpu_a, 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 12; c++) begin
      step();
      fpu_done   = 1'b1;
      fpu_result = $urandom;
      rsp_ready  = 1'b1;
      sample();
      chk("no_ghost_rsp", 32'(rsp_valid | fpu_start), 32'd0);
    end

`ifdef FPU_ISSUE_WDOG_EN
    t[0].a = 32'h1234_5678;
    present(0);
    for (int k = 1; k <= 16; k++) begin
      step();
      idle_req();
      fpu_done = 1'b0;
      sample();
      chk("wdog_exec_start", 32'(fpu_start), 32'd1);
      chk("wdog_exec_trip", 32'(wdog_trip), 32'd0);
      chk("wdog_exec_valid", 32'(rsp_valid), 32'd0);
    end
    step();
    rsp_ready = 1'b0;
    sample();
    chk("wdog_trip", 32'(wdog_trip), 32'd1);
    chk("wdog_valid", 32'(rsp_valid), 32'd1);
    chk("wdog_data", rsp_data, 32'h7FC0_0000);
    chk("wdog_flags", 32'(rsp_flags), 32'h10);
    chk("wdog_fflags", 32'(fflags), 32'h10);
    step();
    sample();
    chk("wdog_pulse_end", 32'(wdog_trip), 32'd0);
    step();
    rsp_ready = 1'b1;
    sample();
    step();
    sample();
    chk("wdog_idle", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
